// File: rtl/sar_pkg.sv
// Shared state encoding, default sizing and width helper for the SAR controller.
package sar_pkg;

   localparam int NBIT_DEF    = 8;
   localparam int NCH_DEF     = 4;
   localparam int TSAMPLE_DEF = 2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SAMPLE = 3'd1;
   localparam logic [2:0] S_PRE    = 3'd2;
   localparam logic [2:0] S_LAT    = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = S_IDLE,
      SAMPLE = S_SAMPLE,
      PRE    = S_PRE,
      LAT    = S_LAT,
      HOLD   = S_HOLD
   } sar_state_e;

   // Channel-select width; a single-channel build still carries one bit.
   function automatic int chw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sar_ctrl_if.sv
// Bundle of control, analog-strobe and result-handshake signals for sar_ctrl.
// master is the controller side; slave is the analog front end / result consumer.
interface sar_ctrl_if
   import sar_pkg::*;
#(
   parameter int NBIT = NBIT_DEF,
   parameter int NCH  = NCH_DEF
);
   localparam int CHW = chw(NCH);

   logic            start;
   logic [CHW-1:0]  start_ch;
   logic            cont;
   logic            cmp_out;
   logic            cmp_outb;
   logic            pdn;
   logic            sample;
   logic            clk_preamp;
   logic            clk_latch;
   logic [NBIT-1:0] dac_code;
   logic [CHW-1:0]  ch_sel;
   logic            busy;
   logic [NBIT-1:0] dout;
   logic [CHW-1:0]  dout_ch;
   logic            dout_err;
   logic            dout_valid;
   logic            dout_ready;

   modport master (
      input  start, start_ch, cont, cmp_out, cmp_outb, dout_ready,
      output pdn, sample, clk_preamp, clk_latch, dac_code, ch_sel, busy,
             dout, dout_ch, dout_err, dout_valid
   );

   modport slave (
      output start, start_ch, cont, cmp_out, cmp_outb, dout_ready,
      input  pdn, sample, clk_preamp, clk_latch, dac_code, ch_sel, busy,
             dout, dout_ch, dout_err, dout_valid
   );

endinterface

// File: rtl/sar_outbuf.sv
// One-entry result register with valid/ready drain; a load wins over a same-cycle drain,
// so a new result can replace the departing one without a bubble.
module sar_outbuf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] payload,
   output logic         valid,
   input  logic         ready,
   output logic         full,
   output logic [W-1:0] data
);

   logic         full_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (load) begin
         full_q <= 1'b1;
         data_q <= payload;
      end else if (full_q && ready) begin
         full_q <= 1'b0;
      end
   end

   assign valid = full_q;
   assign full  = full_q;
   assign data  = data_q;

endmodule

// File: rtl/sar_ctrl.sv
// SAR conversion sequencer: TSAMPLE track cycles, NBIT preamp/latch trials, then result load
// TSAMPLE+2*NBIT+1 cycles after start; a full result buffer parks the FSM in HOLD.
module sar_ctrl
   import sar_pkg::*;
#(
   parameter int NBIT    = NBIT_DEF,
   parameter int NCH     = NCH_DEF,
   parameter int TSAMPLE = TSAMPLE_DEF
) (
   input logic        clk,
   input logic        rstn,
   sar_ctrl_if.master bus
);

   localparam int CHW = chw(NCH);
   localparam int BW  = $clog2(NBIT);
   localparam int CW  = (TSAMPLE > 1) ? $clog2(TSAMPLE) : 1;
   localparam int PW  = NBIT + CHW + 1;

   sar_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [NBIT-1:0] dac_q, dac_d;
   logic [CHW-1:0]  ch_q, ch_d;
   logic            err_q, err_d;
   logic            busy_q, sample_q, pre_q, lat_q;

   logic [CHW-1:0]  ch_next;
   logic            keep_bit, bad_dec;
   logic            buf_full, buf_load;
   logic [PW-1:0]   buf_dat;

   assign ch_next  = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
   assign keep_bit = bus.cmp_out & ~bus.cmp_outb;
   assign bad_dec  = (bus.cmp_out == bus.cmp_outb);
   assign buf_load = (state_q == HOLD) && (!buf_full || bus.dout_ready);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      dac_d   = dac_q;
      ch_d    = ch_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.start || bus.cont) begin
               state_d = SAMPLE;
               cnt_d   = '0;
               err_d   = 1'b0;
               ch_d    = bus.start ? bus.start_ch : ch_next;
            end
         end
         SAMPLE: begin
            if (cnt_q == CW'(TSAMPLE - 1)) begin
               state_d = PRE;
               bit_d   = BW'(NBIT - 1);
               dac_d   = {1'b1, {(NBIT-1){1'b0}}};
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRE: state_d = LAT;
         LAT: begin
            // Decision edge: resolve the trial bit, then arm the next one below it.
            dac_d[bit_q] = keep_bit;
            err_d        = err_q | bad_dec;
            if (bit_q == '0) begin
               state_d = HOLD;
            end else begin
               bit_d        = bit_q - 1'b1;
               dac_d[bit_d] = 1'b1;
               state_d      = PRE;
            end
         end
         HOLD: begin
            if (buf_load) begin
               if (bus.cont) begin
                  state_d = SAMPLE;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  ch_d    = ch_next;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         dac_q    <= '0;
         ch_q     <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         sample_q <= 1'b0;
         pre_q    <= 1'b0;
         lat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         dac_q    <= dac_d;
         ch_q     <= ch_d;
         err_q    <= err_d;
         // Strobes come straight from flops decoded off the next state, so they never glitch.
         busy_q   <= (state_d != IDLE);
         sample_q <= (state_d == SAMPLE);
         pre_q    <= (state_d == PRE);
         lat_q    <= (state_d == LAT);
      end
   end

   sar_outbuf #(.W(PW)) u_outbuf (
      .clk     (clk),
      .rstn    (rstn),
      .load    (buf_load),
      .payload ({dac_q, ch_q, err_q}),
      .valid   (bus.dout_valid),
      .ready   (bus.dout_ready),
      .full    (buf_full),
      .data    (buf_dat)
   );

   assign {bus.dout, bus.dout_ch, bus.dout_err} = buf_dat;

   assign bus.pdn        = busy_q;
   assign bus.busy       = busy_q;
   assign bus.sample     = sample_q;
   assign bus.clk_preamp = pre_q;
   assign bus.clk_latch  = lat_q;
   assign bus.dac_code   = dac_q;
   assign bus.ch_sel     = ch_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Randomized bench for sar_ctrl against a successive-approximation reference model.
module tb_sar_ctrl;

   localparam int NB      = 8;
   localparam int NC      = 4;
   localparam int TS      = 2;
   localparam int LATENCY = TS + 2 * NB + 1;

   logic       clk, rstn;
   logic [7:0] vin;
   int         cmp_mode, bad_bit, cmp_lsb;
   int         n_chk, n_err;
   logic [7:0] exp_tr[$];

   sar_ctrl_if #(.NBIT(NB), .NCH(NC)) bus ();

   sar_ctrl #(.NBIT(NB), .NCH(NC), .TSAMPLE(TS)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation did not terminate");
   end

   // Comparator: 0 ideal, 1 stuck high, 2 stuck low, 3 ideal except both outputs high on bad_bit.
   initial begin
      bus.cmp_out  = 1'b0;
      bus.cmp_outb = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         cmp_lsb = -1;
         for (int i = 7; i >= 0; i--) if (bus.dac_code[i]) cmp_lsb = i;
         if (cmp_mode == 1) begin
            bus.cmp_out = 1'b1; bus.cmp_outb = 1'b0;
         end else if (cmp_mode == 2) begin
            bus.cmp_out = 1'b0; bus.cmp_outb = 1'b1;
         end else if (cmp_mode == 3 && cmp_lsb == bad_bit) begin
            bus.cmp_out = 1'b1; bus.cmp_outb = 1'b1;
         end else begin
            bus.cmp_out  = (vin >= bus.dac_code);
            bus.cmp_outb = !(vin >= bus.dac_code);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {5'd0, bus.dac_code, bus.ch_sel, bus.dout, bus.dout_ch, bus.dout_err,
              bus.dout_valid, bus.busy, bus.pdn, bus.sample, bus.clk_preamp, bus.clk_latch};
   endfunction

   // Binary search over the code space, with the comparator behaviour chosen by mode.
   task automatic model(input logic [7:0] v, input int mode, input int bad,
                        output logic [7:0] res, output logic err);
      logic [7:0] t;
      logic       keep;
      exp_tr.delete();
      res = 8'd0;
      err = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         t = res | (8'd1 << k);
         exp_tr.push_back(t);
         case (mode)
            1:       keep = 1'b1;
            2:       keep = 1'b0;
            3:       keep = (k == bad) ? 1'b0 : (v >= t);
            default: keep = (v >= t);
         endcase
         if (mode == 3 && k == bad) err = 1'b1;
         if (keep) res = t;
      end
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      bus.start = 1'b0;
      bus.cont  = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_valid(input string tag, output int cyc);
      for (cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (bus.dout_valid) break;
      end
      chk(tag, bus.dout_valid, 1);
   endtask

   task automatic conv(input logic [7:0] v, input int mode, input int bad,
                       input logic [1:0] ch, input bit poke);
      logic [7:0] er;
      logic       ee;
      int         k, ns;
      logic [7:0] got[$];
      vin = v; cmp_mode = mode; bad_bit = bad;
      model(v, mode, bad, er, ee);
      @(negedge clk);
      bus.start = 1'b1; bus.start_ch = ch;
      ns = 0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (k == 0) bus.start = 1'b0;
         if (poke && k == 5) begin bus.start = 1'b1; bus.start_ch = ch + 2'd1; end
         if (poke && k == 6) bus.start = 1'b0;
         if (bus.dout_valid) break;
         chk("busy", bus.busy, 1);
         chk("pdn", bus.pdn, 1);
         chk("excl", {31'd0, $onehot0({bus.sample, bus.clk_preamp, bus.clk_latch})}, 1);
         if (bus.sample) ns++;
         if (bus.clk_preamp) got.push_back(bus.dac_code);
      end
      chk("latency", k, LATENCY);
      chk("dout", bus.dout, er);
      chk("dout_ch", bus.dout_ch, ch);
      chk("dout_err", bus.dout_err, ee);
      chk("nsample", ns, TS);
      chk("ntrial", got.size(), exp_tr.size());
      for (int i = 0; i < got.size() && i < exp_tr.size(); i++) chk("trial", got[i], exp_tr[i]);
      chk("idle", bus.busy, 0);
      @(negedge clk);
      chk("drained", bus.dout_valid, 0);
   endtask

   initial begin
      logic [7:0] er;
      logic       ee;
      int         c, last, n, k;
      bit         st;
      n_chk = 0; n_err = 0;
      rstn = 1'b0;
      bus.start = 1'b0; bus.start_ch = '0; bus.cont = 1'b0; bus.dout_ready = 1'b1;
      vin = 8'd0; cmp_mode = 0; bad_bit = -1;
      #12;
      chk("rst_outs", outs(), 0);
      @(negedge clk);
      rstn = 1'b1;

      conv(8'hA5, 0, -1, 2'd2, 1'b0);
      conv(8'h3C, 1, -1, 2'd1, 1'b0);
      conv(8'h3C, 2, -1, 2'd3, 1'b0);
      conv(8'hFF, 3, 5, 2'd0, 1'b0);
      conv(8'hFF, 0, -1, 2'd0, 1'b0);
      for (int i = 0; i < 16; i++)
         conv(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      // Continuous round-robin with the consumer always ready.
      do_reset();
      vin = 8'($urandom_range(0, 255)); cmp_mode = 0;
      model(vin, 0, -1, er, ee);
      @(negedge clk);
      bus.cont = 1'b1;
      last = 0; n = 0;
      for (int t = 0; t < 400 && n < 5; t++) begin
         @(negedge clk);
         if (bus.dout_valid) begin
            chk("cont_ch", bus.dout_ch, (n + 1) % NC);
            chk("cont_dout", bus.dout, er);
            chk("cont_gap", t - last, (n == 0) ? LATENCY : 19);
            last = t;
            n++;
         end
      end
      chk("cont_n", n, 5);
      bus.cont = 1'b0;
      wait_valid("cont_tail", c);
      chk("cont_tail_ch", bus.dout_ch, 2);
      chk("cont_stop", bus.busy, 0);

      // Backpressure: consumer stalls, second result waits in HOLD.
      do_reset();
      vin = 8'($urandom_range(0, 255)); cmp_mode = 0;
      model(vin, 0, -1, er, ee);
      bus.dout_ready = 1'b0;
      @(negedge clk);
      bus.cont = 1'b1;
      wait_valid("bp_first", c);
      chk("bp_lat", c, LATENCY);
      chk("bp_ch1", bus.dout_ch, 1);
      st = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (!bus.dout_valid || bus.dout !== er || bus.dout_ch !== 2'd1) st = 1'b0;
      end
      chk("bp_stable", st, 1);
      chk("bp_hold", {bus.busy, bus.sample, bus.clk_preamp, bus.clk_latch}, 4'b1000);
      chk("bp_dac", bus.dac_code, er);
      bus.dout_ready = 1'b1;
      @(negedge clk);
      chk("bp_second_vld", bus.dout_valid, 1);
      chk("bp_second_ch", bus.dout_ch, 2);
      chk("bp_second", bus.dout, er);
      bus.cont = 1'b0;
      wait_valid("bp_third", c);
      chk("bp_third_ch", bus.dout_ch, 3);
      chk("bp_stop", bus.busy, 0);

      // Reset during the bit-3 latch phase with an older result still buffered.
      bus.dout_ready = 1'b0; vin = 8'h5A; cmp_mode = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.start_ch = 2'd1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_valid("rm_first", c);
      @(negedge clk);
      bus.start = 1'b1; bus.start_ch = 2'd2;
      @(negedge clk);
      bus.start = 1'b0;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.clk_latch && bus.dac_code[3:0] == 4'b1000) break;
      end
      chk("rm_lat3", bus.clk_latch, 1);
      rstn = 1'b0;
      #1;
      chk("rm_outs", outs(), 0);
      repeat (3) @(negedge clk);
      chk("rm_novalid", bus.dout_valid, 0);
      rstn = 1'b1;
      bus.dout_ready = 1'b1;
      conv(8'($urandom_range(0, 255)), 0, -1, 2'd3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
